data_memory_ctrl: RTL and testbench

//  Next-generation CPU data memory: an inferred synchronous RAM with byte/half/word stores.

---
 rtl/data_memory_ctrl_if.sv | 34 +++
 rtl/data_memory_ctrl.sv | 159 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - CPU load/store port and UART programmer port of the data memory
// The CPU/programmer side uses master; the memory controller uses slave.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [ADDR_W+1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_stall;
  logic              misalign_err;
  logic              upg_rst_i;
  logic              upg_wen_i;
  logic [ADDR_W-1:0] upg_adr_i;
  logic [DATA_W-1:0] upg_dat_i;
  logic              upg_done_i;

  modport master (
    output mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
    output upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    input  mem_rdata, mem_rvalid, mem_stall, misalign_err
  );

  modport slave (
    input  mem_req, mem_we, mem_size, mem_unsigned, mem_addr, mem_wdata,
    input  upg_rst_i, upg_wen_i, upg_adr_i, upg_dat_i, upg_done_i,
    output mem_rdata, mem_rvalid, mem_stall, misalign_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - CPU data RAM with byte/half/word access and UART program-mode arbiter
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_memory_ctrl #(
  parameter int    ADDR_W    = 14,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_ctrl_if.slave    bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PROG  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] ram [DEPTH];

  logic              stall;
  logic              mis;
  logic              cpu_go;
  logic              st_en;
  logic              ld_en;
  logic              prog_we;
  logic [1:0]        off;
  logic [ADDR_W-1:0] idx;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] rd_word_q;
  logic [1:0]        rd_off_q;
  logic [1:0]        rd_size_q;
  logic              rd_uns_q;
  logic              rd_ok_q;
  logic              rvalid_q;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [DATA_W-1:0] ext;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b1;
    prog_we = 1'b0;
    case (state_q)
      RUN: begin
        stall = 1'b0;
        if (!bus.upg_rst_i && !bus.upg_done_i) state_d = PROG;
      end
      PROG: begin
        prog_we = bus.upg_wen_i;
        if (bus.upg_rst_i || (bus.upg_done_i && !bus.upg_wen_i)) state_d = DRAIN;
      end
      DRAIN:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Request decode; the UART port only ever reaches the RAM while the CPU is stalled.
  always_comb begin
    off     = bus.mem_addr[1:0];
    idx     = bus.mem_addr[ADDR_W+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
    if (bus.mem_size == 2'd0)      mis = 1'b0;
    else if (bus.mem_size == 2'd1) mis = off[0];
    else                           mis = (off != 2'd0);
`else
    mis = 1'b0;
`endif
    cpu_go  = (state_q == RUN) && bus.mem_req && !mis;
    st_en   = cpu_go && bus.mem_we;
    ld_en   = cpu_go && !bus.mem_we;
    be      = '0;
    wr_data = bus.mem_wdata;
    case (bus.mem_size)
      2'd0: begin
        be[off] = 1'b1;
        wr_data = {NB{bus.mem_wdata[7:0]}};
      end
      2'd1: begin
        be[{off[1], 1'b0}] = 1'b1;
        be[{off[1], 1'b1}] = 1'b1;
        wr_data = {(NB/2){bus.mem_wdata[15:0]}};
      end
      default: be = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (prog_we) begin
      ram[bus.upg_adr_i] <= bus.upg_dat_i;
    end else if (st_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) ram[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (ld_en) rd_word_q <= ram[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      rd_ok_q   <= 1'b0;
      rd_off_q  <= 2'd0;
      rd_size_q <= 2'd0;
      rd_uns_q  <= 1'b0;
    end else begin
      rvalid_q <= ld_en;
      if (ld_en) begin
        rd_ok_q   <= 1'b1;
        rd_off_q  <= off;
        rd_size_q <= bus.mem_size;
        rd_uns_q  <= bus.mem_unsigned;
      end
    end
  end

  // Lane select and extension run on the registered request so the RAM output stays unregistered-free.
  always_comb begin
    sel_b = rd_word_q[{rd_off_q, 3'b000} +: 8];
    sel_h = rd_word_q[{rd_off_q[1], 4'b0000} +: 16];
    case (rd_size_q)
      2'd0:    ext = {{(DATA_W-8){~rd_uns_q & sel_b[7]}}, sel_b};
      2'd1:    ext = {{(DATA_W-16){~rd_uns_q & sel_h[15]}}, sel_h};
      default: ext = rd_word_q;
    endcase
  end

  assign bus.mem_rdata  = rd_ok_q ? ext : '0;
  assign bus.mem_rvalid = rvalid_q;
  assign bus.mem_stall  = stall;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == RUN) && bus.mem_req && mis;
  end

  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized bench with behavioural memory model for data_memory_ctrl
module tb_data_memory_ctrl;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_memory_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] mm [0:(1<<AW)-1];
  logic [31:0] m_rdata;
  bit          m_rvalid, m_stall, m_err;
  bit          prog, drain;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] size, input logic [15:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return a[0];
    return a[1:0] != 2'd0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns, input logic [15:0] a);
    logic [31:0] w;
    logic [31:0] v;
    w = mm[a[15:2]];
    if (size == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  initial for (int i = 0; i < (1<<AW); i++) mm[i] = 32'h0;

  // Reference model: memory array plus a program/drain flag pair
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdata  = 32'h0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      prog     = 1'b0;
      drain    = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      if (!prog && !drain && bus.mem_req) begin
        if (model_mis(bus.mem_size, bus.mem_addr)) begin
          m_err = 1'b1;
        end else if (bus.mem_we) begin
          if (bus.mem_size == 2'd0)
            mm[bus.mem_addr[15:2]][8*bus.mem_addr[1:0] +: 8] = bus.mem_wdata[7:0];
          else if (bus.mem_size == 2'd1)
            mm[bus.mem_addr[15:2]][16*bus.mem_addr[1] +: 16] = bus.mem_wdata[15:0];
          else
            mm[bus.mem_addr[15:2]] = bus.mem_wdata;
        end else begin
          m_rdata  = model_load(bus.mem_size, bus.mem_unsigned, bus.mem_addr);
          m_rvalid = 1'b1;
        end
      end
      if (prog && bus.upg_wen_i) mm[bus.upg_adr_i] = bus.upg_dat_i;
      if (drain) begin
        drain = 1'b0;
      end else if (prog) begin
        if (bus.upg_rst_i || (bus.upg_done_i && !bus.upg_wen_i)) begin
          prog  = 1'b0;
          drain = 1'b1;
        end
      end else if (!bus.upg_rst_i && !bus.upg_done_i) begin
        prog = 1'b1;
      end
    end
    m_stall = prog || drain;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rdata",  bus.mem_rdata,    m_rdata);
      check("cyc_rvalid", 32'(bus.mem_rvalid),   32'(m_rvalid));
      check("cyc_stall",  32'(bus.mem_stall),    32'(m_stall));
      check("cyc_err",    32'(bus.misalign_err), 32'(m_err));
    end
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input bit we, input logic [1:0] size, input bit uns,
                     input logic [15:0] addr, input logic [31:0] wd);
    bus.mem_req      = 1'b1;
    bus.mem_we       = we;
    bus.mem_size     = size;
    bus.mem_unsigned = uns;
    bus.mem_addr     = addr;
    bus.mem_wdata    = wd;
    idle();
    bus.mem_req      = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'd0; bus.mem_unsigned = 1'b0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.upg_rst_i = 1'b1; bus.upg_wen_i = 1'b0; bus.upg_adr_i = '0; bus.upg_dat_i = '0;
    bus.upg_done_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata",  bus.mem_rdata, 32'h0);
    check("rst_rvalid", 32'(bus.mem_rvalid), 32'h0);
    check("rst_stall",  32'(bus.mem_stall), 32'h0);
    check("rst_err",    32'(bus.misalign_err), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle();

    cpu(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEAD_BEEF);
    cpu(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    check("t2_lw", bus.mem_rdata, 32'hDEAD_BEEF);
    check("t2_rvalid", 32'(bus.mem_rvalid), 32'h1);
    idle();
    check("t2_rvalid_drop", 32'(bus.mem_rvalid), 32'h0);
    check("t2_hold", bus.mem_rdata, 32'hDEAD_BEEF);

    cpu(1'b1, 2'd2, 1'b0, 16'h0010, 32'h1122_3344);
    cpu(1'b1, 2'd0, 1'b0, 16'h0013, 32'h0000_0080);
    cpu(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    check("t3_word", bus.mem_rdata, 32'h8022_3344);
    cpu(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
    check("t3_lb", bus.mem_rdata, 32'hFFFF_FF80);
    cpu(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
    check("t3_lbu", bus.mem_rdata, 32'h0000_0080);

    cpu(1'b1, 2'd2, 1'b0, 16'h0000, 32'h0);
    cpu(1'b1, 2'd1, 1'b0, 16'h0002, 32'h0000_ABCD);
    cpu(1'b0, 2'd2, 1'b0, 16'h0000, 32'h0);
    check("t4_word", bus.mem_rdata, 32'hABCD_0000);
    cpu(1'b0, 2'd1, 1'b0, 16'h0002, 32'h0);
    check("t4_lh", bus.mem_rdata, 32'hFFFF_ABCD);
    cpu(1'b0, 2'd1, 1'b1, 16'h0002, 32'h0);
    check("t4_lhu", bus.mem_rdata, 32'h0000_ABCD);

    bus.upg_rst_i = 1'b0;
    bus.upg_done_i = 1'b0;
    idle();
    check("t5_stall", 32'(bus.mem_stall), 32'h1);
    bus.upg_wen_i = 1'b1;
    bus.upg_adr_i = 14'd5;
    bus.upg_dat_i = 32'h1234_5678;
    cpu(1'b1, 2'd2, 1'b0, 16'h0014, 32'hFFFF_FFFF);
    bus.upg_wen_i = 1'b0;
    cpu(1'b0, 2'd2, 1'b0, 16'h0014, 32'h0);
    check("t5_no_rvalid", 32'(bus.mem_rvalid), 32'h0);
    bus.upg_done_i = 1'b1;
    idle();
    check("t5_drain_stall", 32'(bus.mem_stall), 32'h1);
    idle();
    check("t5_run_stall", 32'(bus.mem_stall), 32'h0);
    cpu(1'b0, 2'd2, 1'b0, 16'h0014, 32'h0);
    check("t5_lw", bus.mem_rdata, 32'h1234_5678);
    bus.upg_rst_i = 1'b1;

    cpu(1'b0, 2'd2, 1'b0, 16'h0002, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t6_err", 32'(bus.misalign_err), 32'h1);
    check("t6_no_rvalid", 32'(bus.mem_rvalid), 32'h0);
`else
    check("t6_aligned_down", bus.mem_rdata, 32'hABCD_0000);
    check("t6_rvalid", 32'(bus.mem_rvalid), 32'h1);
    cpu(1'b0, 2'd1, 1'b0, 16'h0003, 32'h0);
    check("t6_lh_odd", bus.mem_rdata, 32'hFFFF_ABCD);
`endif

    cpu(1'b1, 2'd2, 1'b0, 16'hFFFC, 32'hCAFE_F00D);
    cpu(1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0);
    check("top_word", bus.mem_rdata, 32'hCAFE_F00D);

    for (int n = 0; n < 1500; n++) begin
      bus.mem_req      = ($urandom_range(0, 3) != 0);
      bus.mem_we       = 1'($urandom_range(0, 1));
      bus.mem_size     = 2'($urandom_range(0, 3));
      bus.mem_unsigned = 1'($urandom_range(0, 1));
      bus.mem_addr     = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      bus.mem_wdata    = $urandom;
      bus.upg_rst_i    = ($urandom_range(0, 2) == 0);
      bus.upg_done_i   = ($urandom_range(0, 2) == 0);
      bus.upg_wen_i    = 1'($urandom_range(0, 1));
      bus.upg_adr_i    = 14'($urandom_range(0, 15));
      bus.upg_dat_i    = $urandom;
      idle();
    end
    bus.mem_req = 1'b0;
    bus.upg_wen_i = 1'b0;
    bus.upg_rst_i = 1'b1;
    bus.upg_done_i = 1'b1;
    repeat (2) idle();

    cpu(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
    check("t1_pre_rvalid", 32'(bus.mem_rvalid), 32'h1);
    rst = 1'b1;
    #1;
    check("t1_rvalid", 32'(bus.mem_rvalid), 32'h0);
    check("t1_rdata",  bus.mem_rdata, 32'h0);
    check("t1_stall",  32'(bus.mem_stall), 32'h0);
    #1;
    rst = 1'b0;
    idle();

    bus.upg_rst_i = 1'b0;
    bus.upg_done_i = 1'b0;
    idle();
    check("t1_prog_stall", 32'(bus.mem_stall), 32'h1);
    bus.upg_rst_i = 1'b1;
    rst = 1'b1;
    #1;
    check("t1_prog_abort", 32'(bus.mem_stall), 32'h0);
    #1;
    rst = 1'b0;
    repeat (3) idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
